// File: rtl/vending_pkg.sv
// Shared types, coin values and coin decode for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PENDING = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

  // Value of a single inserted coin; no coin or several coins at once decode to 0.
  function automatic logic [7:0] coin_value(input logic q, input logic d, input logic n);
    logic [7:0] v;
    case ({q, d, n})
      3'b100:  v = 8'(QUARTER_C);
      3'b010:  v = 8'(DIME_C);
      3'b001:  v = 8'(NICKEL_C);
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_unit.sv
// Greedy change picker: largest coin that fits the given credit, combinational.
// Outputs the coin one-hot {quarter, dime, nickel} and the amount to subtract.
module change_unit
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [2:0]          coin,
  output logic [CREDIT_W-1:0] dec
);

  always_comb begin
    coin = 3'b000;
    dec  = '0;
    if (credit >= CREDIT_W'(QUARTER_C)) begin
      coin = 3'b100;
      dec  = CREDIT_W'(QUARTER_C);
    end else if (credit >= CREDIT_W'(DIME_C)) begin
      coin = 3'b010;
      dec  = CREDIT_W'(DIME_C);
    end else if (credit != '0) begin
      coin = 3'b001;
      dec  = CREDIT_W'(NICKEL_C);
    end
  end

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin accept, held selection, auto-dispense, cancel and greedy change.
// Every output is registered; inputs sampled at an edge act on the outputs of the following cycle.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS  = 2,
  parameter int PRICE      = 45,
  parameter int MAX_CREDIT = 95,
  parameter int CREDIT_W   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 nickel,
  input  logic                 dime,
  input  logic                 quarter,
  input  logic [NUM_ITEMS-1:0] select,
  input  logic                 cancel,
  output logic [NUM_ITEMS-1:0] give,
  output logic                 chg_nickel,
  output logic                 chg_dime,
  output logic                 chg_quarter,
  output logic                 coin_reject,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

  state_t                 state;
  logic [NUM_ITEMS-1:0]   sel_reg;

  logic [CREDIT_W-1:0]    coin_val;
  logic [CREDIT_W-1:0]    sum;
  logic [CREDIT_W-1:0]    credit_next;
  logic                   coin_any;
  logic                   coin_ok;
  logic [NUM_ITEMS-1:0]   sel_low;
  logic [NUM_ITEMS-1:0]   sel_next;
  logic [2:0]             chg_coin;
  logic [CREDIT_W-1:0]    chg_dec;

  // The picker always works on the live credit: VEND, CHANGE and cancel all refund from it.
  change_unit #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .credit (credit),
    .coin   (chg_coin),
    .dec    (chg_dec)
  );

  always_comb begin
    coin_val    = CREDIT_W'(coin_value(quarter, dime, nickel));
    coin_any    = nickel | dime | quarter;
    sum         = credit + coin_val;
    coin_ok     = (coin_val != '0) && (sum <= MAX_C);
    credit_next = coin_ok ? sum : credit;
    // Isolate the lowest set request bit.
    sel_low     = select & (~select + NUM_ITEMS'(1));
    sel_next    = (|select) ? sel_low : sel_reg;
  end

  assign busy = (state == VEND) || (state == CHANGE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      credit      <= '0;
      sel_reg     <= '0;
      give        <= '0;
      chg_quarter <= 1'b0;
      chg_dime    <= 1'b0;
      chg_nickel  <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      give        <= '0;
      chg_quarter <= 1'b0;
      chg_dime    <= 1'b0;
      chg_nickel  <= 1'b0;
      coin_reject <= 1'b0;

      case (state)
        COLLECT, PENDING: begin
          if (cancel) begin
            coin_reject <= coin_any;
            sel_reg     <= '0;
            if (credit != '0) begin
              state                              <= CHANGE;
              {chg_quarter, chg_dime, chg_nickel} <= chg_coin;
              credit                             <= credit - chg_dec;
            end else begin
              state <= COLLECT;
            end
          end else begin
            coin_reject <= coin_any & ~coin_ok;
            credit      <= credit_next;
            if (|sel_next) begin
              if (credit_next >= PRICE_C) begin
                state   <= VEND;
                give    <= sel_next;
                credit  <= credit_next - PRICE_C;
                sel_reg <= '0;
              end else begin
                state   <= PENDING;
                sel_reg <= sel_next;
              end
            end else begin
              state <= COLLECT;
            end
          end
        end

        VEND, CHANGE: begin
          coin_reject <= coin_any;
          if (credit != '0) begin
            state                              <= CHANGE;
            {chg_quarter, chg_dime, chg_nickel} <= chg_coin;
            credit                             <= credit - chg_dec;
          end else begin
            state <= COLLECT;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule
